// File: rtl/bram_dp_arb_if.sv
// One memory port of bram_dp_arb: valid/ready request channel plus read-return channel.
interface bram_dp_arb_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
);
  logic                    valid;
  logic                    ready;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] be;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    rvalid;
  logic [DATA_WIDTH-1:0]   rdata;

  modport master (output valid, we, be, addr, wdata, input  ready, rvalid, rdata);
  modport slave  (input  valid, we, be, addr, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/bram_dp_arb.sv
// True dual-port RAM with byte-enable writes, 1/2-cycle read latency and round-robin collision
// arbitration. Define BRAM_COLL_CNT_EN to add the saturating coll_cnt collision counter port.
module bram_dp_arb #(
  parameter int    DATA_WIDTH = 16,
  parameter int    ADDR_WIDTH = 10,
  parameter int    RD_LAT     = 1,
  parameter string INIT_FILE  = ""
) (
  input  logic         clk,
  input  logic         rst,
  bram_dp_arb_if.slave a,
  bram_dp_arb_if.slave b
`ifdef BRAM_COLL_CNT_EN
  ,
  output logic [15:0]  coll_cnt
`endif
);
  localparam int NBYTES    = DATA_WIDTH / 8;
  localparam int DEPTH     = 2 ** ADDR_WIDTH;
  localparam int NUM_PORTS = 2;

  typedef enum logic {PRIO_A = 1'b0, PRIO_B = 1'b1} prio_e;

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [NBYTES-1:0]     be;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  req_t  [NUM_PORTS-1:0]                 req;
  logic  [NUM_PORTS-1:0]                 ready;
  logic  [NUM_PORTS-1:0]                 acc;
  logic  [NUM_PORTS-1:0]                 rvalid;
  logic  [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata;
  prio_e                                 prio, prio_nxt;
  logic                                  coll;

  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
    $error("bram_dp_arb: RD_LAT must be 1 or 2");
  end

  assign req[0] = '{a.valid, a.we, a.be, a.addr, a.wdata};
  assign req[1] = '{b.valid, b.we, b.be, b.addr, b.wdata};

  // Only same-address pairs involving a write conflict; read/read is served to both.
  assign coll = req[0].valid & req[1].valid & (req[0].addr == req[1].addr) &
                (req[0].we | req[1].we);

  always_comb begin
    ready    = '1;
    prio_nxt = prio;
    if (coll) begin
      ready[0] = (prio == PRIO_A);
      ready[1] = (prio == PRIO_B);
      prio_nxt = (prio == PRIO_A) ? PRIO_B : PRIO_A;
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) prio <= PRIO_A;
    else     prio <= prio_nxt;

  assign acc = ready & {req[1].valid, req[0].valid};

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Arbitration guarantees the two ports never write the same word in one cycle.
  always_ff @(posedge clk)
    for (int p = 0; p < NUM_PORTS; p++)
      if (acc[p] && req[p].we)
        for (int i = 0; i < NBYTES; i++)
          if (req[p].be[i]) mem[req[p].addr][8*i +: 8] <= req[p].wdata[8*i +: 8];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [RD_LAT:0]                 vld_pipe;
    logic [RD_LAT:0][DATA_WIDTH-1:0] d_pipe;

    assign vld_pipe[0] = acc[p] & ~req[p].we;
    assign d_pipe[0]   = mem[req[p].addr];

    // Data stages load only behind a valid read, so rdata holds between results.
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        vld_pipe[RD_LAT:1] <= '0;
        d_pipe[RD_LAT:1]   <= '0;
      end else begin
        for (int s = 1; s <= RD_LAT; s++) begin
          vld_pipe[s] <= vld_pipe[s-1];
          if (vld_pipe[s-1]) d_pipe[s] <= d_pipe[s-1];
        end
      end

    assign rvalid[p] = vld_pipe[RD_LAT];
    assign rdata[p]  = d_pipe[RD_LAT];
  end

  assign a.ready  = ready[0];
  assign b.ready  = ready[1];
  assign a.rvalid = rvalid[0];
  assign b.rvalid = rvalid[1];
  assign a.rdata  = rdata[0];
  assign b.rdata  = rdata[1];

`ifdef BRAM_COLL_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst)                              coll_cnt <= '0;
    else if (coll && coll_cnt != 16'hFFFF) coll_cnt <= coll_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_bram_dp_arb.sv
// Bench for bram_dp_arb: RD_LAT=1 and RD_LAT=2 instances share stimulus, checked every cycle
// against a queue-based model plus directed literal expectations.
module tb_bram_dp_arb;
  localparam int DW = 16;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          v  [2];
  logic          we [2];
  logic [1:0]    be [2];
  logic [AW-1:0] ad [2];
  logic [DW-1:0] wd [2];

  bram_dp_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) a1 (), b1 (), a2 (), b2 ();
  assign a1.valid = v[0]; assign a1.we = we[0]; assign a1.be = be[0]; assign a1.addr = ad[0]; assign a1.wdata = wd[0];
  assign b1.valid = v[1]; assign b1.we = we[1]; assign b1.be = be[1]; assign b1.addr = ad[1]; assign b1.wdata = wd[1];
  assign a2.valid = v[0]; assign a2.we = we[0]; assign a2.be = be[0]; assign a2.addr = ad[0]; assign a2.wdata = wd[0];
  assign b2.valid = v[1]; assign b2.we = we[1]; assign b2.be = be[1]; assign b2.addr = ad[1]; assign b2.wdata = wd[1];

`ifdef BRAM_COLL_CNT_EN
  logic [15:0] cc1, cc2;
`endif

  bram_dp_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1)
`ifdef BRAM_COLL_CNT_EN
    , .coll_cnt(cc1)
`endif
  );
  bram_dp_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .a(a2), .b(b2)
`ifdef BRAM_COLL_CNT_EN
    , .coll_cnt(cc2)
`endif
  );

  // [instance][port] views of the outputs
  logic          rdy_o [2][2];
  logic          rv_o  [2][2];
  logic [DW-1:0] rd_o  [2][2];
  assign rdy_o[0][0] = a1.ready;  assign rdy_o[0][1] = b1.ready;
  assign rdy_o[1][0] = a2.ready;  assign rdy_o[1][1] = b2.ready;
  assign rv_o[0][0]  = a1.rvalid; assign rv_o[0][1]  = b1.rvalid;
  assign rv_o[1][0]  = a2.rvalid; assign rv_o[1][1]  = b2.rvalid;
  assign rd_o[0][0]  = a1.rdata;  assign rd_o[0][1]  = b1.rdata;
  assign rd_o[1][0]  = a2.rdata;  assign rd_o[1][1]  = b2.rdata;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int due; logic [DW-1:0] data; } res_t;
  res_t          rq   [2][2][$];
  logic [DW-1:0] mmem [1 << AW];
  logic          m_prio_b;
  logic          e_rv [2][2];
  logic [DW-1:0] e_rd [2][2];
  int            edge_no;
  int            m_cc;

  function automatic logic m_coll();
    return v[0] && v[1] && (ad[0] == ad[1]) && (we[0] || we[1]);
  endfunction

  function automatic logic m_ready(input int p);
    if (!m_coll()) return 1'b1;
    return (p == 1) ? m_prio_b : !m_prio_b;
  endfunction

  task automatic model_reset();
    m_prio_b = 1'b0;
    m_cc     = 0;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        rq[d][p].delete();
        e_rv[d][p] = 1'b0;
        e_rd[d][p] = '0;
      end
  endtask

  // State after the upcoming rising edge, given the inputs currently applied.
  task automatic model_edge();
    logic acc [2];
    logic c;
    edge_no++;
    c = m_coll();
    for (int p = 0; p < 2; p++) acc[p] = v[p] && m_ready(p);
    for (int p = 0; p < 2; p++)
      if (acc[p] && !we[p])
        for (int d = 0; d < 2; d++) rq[d][p].push_back('{due: edge_no + d, data: mmem[ad[p]]});
    for (int p = 0; p < 2; p++)
      if (acc[p] && we[p])
        for (int i = 0; i < 2; i++)
          if (be[p][i]) mmem[ad[p]][8*i +: 8] = wd[p][8*i +: 8];
    if (c) begin
      m_prio_b = !m_prio_b;
      if (m_cc < 16'hFFFF) m_cc++;
    end
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++)
        if (rq[d][p].size() > 0 && rq[d][p][0].due == edge_no) begin
          e_rv[d][p] = 1'b1;
          e_rd[d][p] = rq[d][p][0].data;
          void'(rq[d][p].pop_front());
        end else begin
          e_rv[d][p] = 1'b0;
        end
  endtask

  initial begin
    edge_no = 0;
    forever begin
      @(negedge clk);
      if (rst) model_reset();
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < 2; p++) begin
          chk($sformatf("cyc lat%0d p%0d ready", d + 1, p), rdy_o[d][p], m_ready(p));
          chk($sformatf("cyc lat%0d p%0d rvalid", d + 1, p), rv_o[d][p], e_rv[d][p]);
          chk($sformatf("cyc lat%0d p%0d rdata", d + 1, p), rd_o[d][p], e_rd[d][p]);
        end
`ifdef BRAM_COLL_CNT_EN
      chk("cyc coll_cnt lat1", cc1, m_cc);
      chk("cyc coll_cnt lat2", cc2, m_cc);
`endif
      if (!rst) model_edge();
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input int p, input logic vv, input logic w, input logic [1:0] bb,
                       input logic [AW-1:0] aa, input logic [DW-1:0] dd);
    v[p] = vv; we[p] = w; be[p] = bb; ad[p] = aa; wd[p] = dd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    for (int p = 0; p < 2; p++) drive(p, 1'b0, 1'b0, 2'b00, '0, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset a_rvalid", a1.rvalid, 1'b0);
    chk("reset a_rdata", a1.rdata, 16'h0);
    chk("reset b_rdata lat2", b2.rdata, 16'h0);
`ifdef BRAM_COLL_CNT_EN
    chk("reset coll_cnt", cc1, 16'h0);
`endif

    // 1: write then read back, RD_LAT=1 result one cycle after accept
    drive(0, 1, 1, 2'b11, 10'h010, 16'h1234); step();
    drive(0, 1, 0, 2'b00, 10'h010, 16'h0);    step();
    drive(0, 0, 0, 2'b00, 10'h000, 16'h0);
    chk("t1 lat1 rvalid", a1.rvalid, 1'b1);
    chk("t1 lat1 rdata", a1.rdata, 16'h1234);
    chk("t1 lat2 not yet", a2.rvalid, 1'b0);
    step();
    chk("t1 lat2 rvalid", a2.rvalid, 1'b1);
    chk("t1 lat2 rdata", a2.rdata, 16'h1234);
    chk("t1 lat1 rvalid drops", a1.rvalid, 1'b0);
    chk("t1 lat1 rdata holds", a1.rdata, 16'h1234);

    // 2: back-to-back reads, RD_LAT=2 gives 4 consecutive results
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 1, 2'b11, AW'(i), DW'(16'h1000 + i)); step();
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 2'b00, AW'(i), 16'h0); step();
      chk($sformatf("t2 lat2 rvalid %0d", i), a2.rvalid, i >= 1);
      if (i >= 1) chk($sformatf("t2 lat2 rdata %0d", i), a2.rdata, 16'h1000 + i - 1);
    end
    drive(0, 0, 0, 2'b00, 10'h000, 16'h0); step();
    chk("t2 lat2 last rvalid", a2.rvalid, 1'b1);
    chk("t2 lat2 last rdata", a2.rdata, 16'h1003);
    step();
    chk("t2 lat2 rvalid off", a2.rvalid, 1'b0);
    chk("t2 lat2 rdata holds", a2.rdata, 16'h1003);

    // 3: partial byte write and be=00 no-op
    drive(1, 1, 1, 2'b11, 10'h020, 16'hAAAA); step();
    drive(1, 0, 0, 2'b00, 10'h000, 16'h0);
    drive(0, 1, 1, 2'b01, 10'h020, 16'hBBCC); step();
    drive(0, 1, 1, 2'b00, 10'h020, 16'hFFFF); step();
    drive(0, 1, 0, 2'b00, 10'h020, 16'h0);    step();
    drive(0, 0, 0, 2'b00, 10'h000, 16'h0);
    chk("t3 byte merge", a1.rdata, 16'hAACC);

    // 4: write/write collision, alternating winner
    drive(0, 1, 1, 2'b11, 10'h030, 16'h1111);
    drive(1, 1, 1, 2'b11, 10'h030, 16'h2222);
    #1;
    chk("t4 c1 a_ready", a1.ready, 1'b1);
    chk("t4 c1 b_ready", b1.ready, 1'b0);
    step();
    drive(0, 0, 0, 2'b00, 10'h000, 16'h0);
    #1;
    chk("t4 b accepted", b1.ready, 1'b1);
    step();
    drive(0, 1, 1, 2'b11, 10'h030, 16'h3333);
    drive(1, 1, 1, 2'b11, 10'h030, 16'h4444);
    #1;
    chk("t4 c2 a_ready", a1.ready, 1'b0);
    chk("t4 c2 b_ready", b1.ready, 1'b1);
    step();
    drive(1, 0, 0, 2'b00, 10'h000, 16'h0);
    step();
    drive(0, 1, 0, 2'b00, 10'h030, 16'h0); step();
    drive(0, 0, 0, 2'b00, 10'h000, 16'h0);
    chk("t4 final word", a1.rdata, 16'h3333);
`ifdef BRAM_COLL_CNT_EN
    chk("t4 coll_cnt", cc1, 16'd2);
`endif

    // 5: read/read same address is not a collision
    drive(0, 1, 1, 2'b11, 10'h040, 16'h5A5A); step();
    drive(0, 1, 0, 2'b00, 10'h040, 16'h0);
    drive(1, 1, 0, 2'b00, 10'h040, 16'h0);
    #1;
    chk("t5 a_ready", a1.ready, 1'b1);
    chk("t5 b_ready", b1.ready, 1'b1);
    step();
    drive(0, 0, 0, 2'b00, 10'h000, 16'h0);
    drive(1, 0, 0, 2'b00, 10'h000, 16'h0);
    chk("t5 a_rvalid", a1.rvalid, 1'b1);
    chk("t5 b_rvalid", b1.rvalid, 1'b1);
    chk("t5 b_rdata", b1.rdata, 16'h5A5A);
`ifdef BRAM_COLL_CNT_EN
    chk("t5 coll_cnt", cc1, 16'd2);
`endif
    // top address
    drive(1, 1, 1, 2'b11, 10'h3FF, 16'h7E7E); step();
    drive(1, 1, 0, 2'b00, 10'h3FF, 16'h0);    step();
    drive(1, 0, 0, 2'b00, 10'h000, 16'h0);
    chk("t5 top addr", b1.rdata, 16'h7E7E);

    // 6: reset kills an in-flight read
    drive(1, 1, 0, 2'b00, 10'h040, 16'h0); step();
    drive(1, 0, 0, 2'b00, 10'h000, 16'h0);
    rst = 1'b1;
    #1;
    chk("t6 lat2 b_rvalid", b2.rvalid, 1'b0);
    chk("t6 lat2 b_rdata", b2.rdata, 16'h0);
    chk("t6 lat1 b_rvalid", b1.rvalid, 1'b0);
    step();
    rst = 1'b0;
    step();
    chk("t6 after b_rvalid", b2.rvalid, 1'b0);
    chk("t6 after b_rdata", b2.rdata, 16'h0);
    drive(0, 1, 1, 2'b11, 10'h050, 16'h0101);
    drive(1, 1, 1, 2'b11, 10'h050, 16'h0202);
    #1;
    chk("t6 prio a_ready", a1.ready, 1'b1);
    chk("t6 prio b_ready", b1.ready, 1'b0);
    step();
    drive(0, 0, 0, 2'b00, 10'h000, 16'h0);
    step();
    drive(1, 0, 0, 2'b00, 10'h000, 16'h0);
`ifdef BRAM_COLL_CNT_EN
    chk("t6 coll_cnt", cc1, 16'd1);
`endif
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
